// File: rtl/spi_coeff_loader.sv
// -----------------------------------------------------------------------------
// spi_coeff_loader
//
// Mode-0 SPI slave (MSB first) that receives one frame of NTaps coefficient
// bytes into a shadow bank. A complete frame is copied to the active bank
// only when the FIR signals a sample boundary. This keeps every output
// sample computed with a single, consistent set of taps.
//
// Ports
//   clk           system clock (the only clock)
//   resetN        asynchronous active-low reset
//   spiClk        SPI clock pin (asynchronous, synchronised here)
//   mosi          SPI data pin (asynchronous, synchronised here)
//   cs            SPI chip select pin, active low (asynchronous)
//   sampleStrobe  one-cycle pulse from the FIR; commit point
//   coeffs        active bank, tap k at [k*DataWidth +: DataWidth]
//   coeffValid    high once any frame has been committed since reset
//   updatePulse   one-cycle pulse in the cycle the active bank changes
//   frameError    sticky bad-frame flag, cleared by the next good commit
//   dbgState      current FSM state (0 IDLE, 1 RECV, 2 PENDING)
// -----------------------------------------------------------------------------
module spi_coeff_loader #(
  parameter int NTaps     = 11,
  parameter int DataWidth = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       spiClk,
  input  logic                       mosi,
  input  logic                       cs,
  input  logic                       sampleStrobe,
  output logic [NTaps*DataWidth-1:0] coeffs,
  output logic                       coeffValid,
  output logic                       updatePulse,
  output logic                       frameError,
  output logic [1:0]                 dbgState
);

  localparam int TapW = $clog2(NTaps + 1);
  localparam logic [TapW-1:0] TapsFull = TapW'(NTaps);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    PENDING = 2'd2
  } state_e;

  // Synchronisers: [0] first stage, [1] synchronised value, [2] edge history.
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  // After reset the cs synchroniser holds its reset value (1). If the pin is
  // actually low, the first real sample would look like a falling edge. A
  // falling edge only counts once cs has genuinely been seen high.
  logic [1:0] fill_q;
  logic       armed_q;

  state_e                     state_q, state_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [TapW-1:0]            tap_cnt_q, tap_cnt_d;
  logic [DataWidth-2:0]       shift_q, shift_d;
  logic                       overrun_q, overrun_d;
  logic [NTaps*DataWidth-1:0] shadow_q, shadow_d;
  logic [NTaps*DataWidth-1:0] coeffs_q, coeffs_d;
  logic                       valid_q, valid_d;
  logic                       update_q, update_d;
  logic                       err_q, err_d;

  logic sclk_rise, cs_fall, cs_rise, mosi_s;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2] & armed_q;
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spiClk};
      cs_sync_q   <= {cs_sync_q[1:0], cs};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      // fill_q == 2 means cs_sync_q[1] now holds a real pin sample.
      if (fill_q == 2'd2 && cs_sync_q[1]) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tap_cnt_d = tap_cnt_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    shadow_d  = shadow_q;
    coeffs_d  = coeffs_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = 3'd0;
          tap_cnt_d = '0;
          overrun_d = 1'b0;
          state_d   = RECV;
        end
      end

      RECV: begin
        // A bit arriving in the same cycle as the cs rise is taken before the
        // frame is judged, so the evaluation below uses the _d values.
        if (sclk_rise) begin
          shift_d   = {shift_q[DataWidth-3:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (tap_cnt_q < TapsFull) begin
              shadow_d[int'(tap_cnt_q)*DataWidth +: DataWidth] = {shift_q, mosi_s};
              tap_cnt_d = tap_cnt_q + TapW'(1);
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        if (cs_rise) begin
          if (tap_cnt_d == TapsFull && bit_cnt_d == 3'd0 && !overrun_d) begin
            state_d = PENDING;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      PENDING: begin
        if (sampleStrobe) begin
          coeffs_d = shadow_q;
          update_d = 1'b1;
          valid_d  = 1'b1;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
        // A new frame started while a commit is outstanding is ignored but
        // flagged; the flag wins over a coincident commit clearing it.
        if (cs_fall) err_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      tap_cnt_q <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
      shadow_q  <= '0;
      coeffs_q  <= '0;
      valid_q   <= 1'b0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tap_cnt_q <= tap_cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
      shadow_q  <= shadow_d;
      coeffs_q  <= coeffs_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      err_q     <= err_d;
    end
  end

  assign coeffs      = coeffs_q;
  assign coeffValid  = valid_q;
  assign updatePulse = update_q;
  assign frameError  = err_q;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_spi_coeff_loader.sv
// -----------------------------------------------------------------------------
// Bench for spi_coeff_loader: table of frames applied in a loop, followed by
// hand-written sequences for commit deferral, busy frames and reset
// mid-frame. Committed banks are predicted into exp_q and checked when
// updatePulse fires.
// -----------------------------------------------------------------------------
module tb_spi_coeff_loader;

  localparam int NT = 11;
  localparam int DW = 8;
  localparam int BW = NT * DW;

  logic          clk;
  logic          resetN;
  logic          spiClk;
  logic          mosi;
  logic          cs;
  logic          sampleStrobe;
  logic [BW-1:0] coeffs;
  logic          coeffValid;
  logic          updatePulse;
  logic          frameError;
  logic [1:0]    dbgState;

  spi_coeff_loader #(.NTaps(NT), .DataWidth(DW)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .spiClk       (spiClk),
    .mosi         (mosi),
    .cs           (cs),
    .sampleStrobe (sampleStrobe),
    .coeffs       (coeffs),
    .coeffValid   (coeffValid),
    .updatePulse  (updatePulse),
    .frameError   (frameError),
    .dbgState     (dbgState)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [BW-1:0] model_active;
  logic          model_valid;
  logic          model_err;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every updatePulse must match a predicted commit.
  always @(negedge clk) begin
    if (resetN && updatePulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        check("commit_data", coeffs, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi   = b[7-i];
      spiClk = 1'b0;
      wait_clks(4);
      spiClk = 1'b1;
      wait_clks(4);
      spiClk = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_end();
    wait_clks(4);
    cs = 1'b1;
    wait_clks(6);
  endtask

  function automatic logic [BW-1:0] make_frame(input logic [7:0] start, input logic [7:0] step);
    logic [BW-1:0] f;
    f = '0;
    for (int k = 0; k < NT; k++) f[k*DW +: DW] = start + 8'(k) * step;
    return f;
  endfunction

  task automatic send_frame(input int nbytes, input int xbits,
                            input logic [7:0] start, input logic [7:0] step);
    cs_start();
    for (int k = 0; k < nbytes; k++) spi_bits(start + 8'(k) * step, 8);
    if (xbits > 0) spi_bits(8'hE0, xbits);
    cs_end();
  endtask

  // Strobe for one cycle; updatePulse must follow one cycle later, for one cycle.
  task automatic do_strobe(input logic exp_commit);
    @(negedge clk);
    sampleStrobe = 1'b1;
    @(negedge clk);
    sampleStrobe = 1'b0;
    check("update_pulse", updatePulse, exp_commit);
    @(negedge clk);
    check("update_width", updatePulse, 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_coeffs"}, coeffs, model_active);
    check({tag, "_valid"}, coeffValid, model_valid);
    check({tag, "_err"}, frameError, model_err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         nbytes;
    int         xbits;
    logic [7:0] start;
    logic [7:0] step;
    bit         good;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [BW-1:0] fa, fb;

    vecs[0] = '{11, 0, 8'h01, 8'h01, 1'b1};  // 0x01..0x0B
    vecs[1] = '{10, 0, 8'h55, 8'h01, 1'b0};  // short by one byte
    vecs[2] = '{11, 0, 8'h7F, 8'h00, 1'b1};  // 0x7F x 11 clears the error
    vecs[3] = '{11, 3, 8'hA0, 8'h01, 1'b0};  // 3 stray bits
    vecs[4] = '{12, 0, 8'hC3, 8'h00, 1'b0};  // overrun
    vecs[5] = '{11, 0, 8'hF5, 8'h03, 1'b1};  // negative / wrapping taps

    resetN       = 1'b0;
    spiClk       = 1'b0;
    mosi         = 1'b0;
    cs           = 1'b1;
    sampleStrobe = 1'b0;
    model_active = '0;
    model_valid  = 1'b0;
    model_err    = 1'b0;

    wait_clks(3);
    check_outputs("reset");
    check("reset_update", updatePulse, 0);
    check("reset_state", dbgState, 0);
    resetN = 1'b1;
    wait_clks(5);

    for (int v = 0; v < 6; v++) begin
      fa = make_frame(vecs[v].start, vecs[v].step);
      send_frame(vecs[v].nbytes, vecs[v].xbits, vecs[v].start, vecs[v].step);
      // Bad frames set the flag immediately; a good frame leaves it as it was.
      check($sformatf("vec%0d_err_at_cs", v), frameError, vecs[v].good ? model_err : 1'b1);
      check($sformatf("vec%0d_state", v), dbgState, vecs[v].good ? 2 : 0);
      check($sformatf("vec%0d_hold", v), coeffs, model_active);
      if (vecs[v].good) begin
        exp_q.push_back(fa);
        model_active = fa;
        model_valid  = 1'b1;
        model_err    = 1'b0;
      end else begin
        model_err = 1'b1;
      end
      do_strobe(vecs[v].good);
      check_outputs($sformatf("vec%0d", v));
      if (v == 0) begin
        check("tap0", coeffs[7:0], 8'h01);
        check("tap10", coeffs[87:80], 8'h0B);
      end
    end

    // Commit deferral: the bank holds until the strobe arrives.
    fa = make_frame(8'h33, 8'h11);
    send_frame(11, 0, 8'h33, 8'h11);
    for (int i = 0; i < 10; i++) begin
      wait_clks(10);
      check("defer_hold", coeffs, model_active);
    end
    check("defer_state", dbgState, 2);
    exp_q.push_back(fa);
    model_active = fa;
    do_strobe(1'b1);
    check_outputs("defer");

    // Busy: frame B arrives while A is still pending and is ignored.
    fa = make_frame(8'h10, 8'h00);
    fb = make_frame(8'h20, 8'h00);
    send_frame(11, 0, 8'h10, 8'h00);
    send_frame(11, 0, 8'h20, 8'h00);
    check("busy_err", frameError, 1);
    check("busy_state", dbgState, 2);
    check("busy_hold", coeffs, model_active);
    exp_q.push_back(fa);
    model_active = fa;
    model_err    = 1'b0;
    do_strobe(1'b1);
    check_outputs("busy");
    check("busy_not_b", (coeffs == fb), 0);

    // Reset mid-frame with cs still low at release.
    cs_start();
    for (int k = 0; k < 5; k++) spi_bits(8'h44, 8);
    resetN       = 1'b0;
    model_active = '0;
    model_valid  = 1'b0;
    model_err    = 1'b0;
    wait_clks(2);
    check_outputs("in_reset");
    resetN = 1'b1;
    wait_clks(2);
    check_outputs("post_reset");
    for (int k = 0; k < 6; k++) spi_bits(8'h66, 8);
    cs_end();
    check("rst_state", dbgState, 0);
    do_strobe(1'b0);
    check_outputs("rst_final");

    wait_clks(4);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_coeff_loader.md
# spi_coeff_loader

Clock-domain-crossing SPI slave that receives FIR coefficient frames from the external controller (pins `cs`, `mosi`, `spiClk`) and presents a stable, double-buffered coefficient bank to `FIREngine`. It sits directly upstream of the FIR datapath.

- Bytes are shifted into a shadow bank.
- A complete frame is committed to the active bank only on a sample boundary signalled by the FIR, so the filter never mixes old and new taps within one output sample.

## Interface
Parameters:
- `NTaps`, 11, number of coefficients per frame.
- `DataWidth`, 8, bits per coefficient; one SPI byte per coefficient. `DataWidth` must equal 8.

Ports:
- `clk`  input  1  system clock; the only clock in the block.
- `resetN`  input  1  asynchronous, active-low reset.
- `spiClk`  input  1  SPI clock from pin, asynchronous to `clk`.
- `mosi`  input  1  SPI data from pin, asynchronous.
- `cs`  input  1  SPI chip select from pin, active low, asynchronous.
- `sampleStrobe`  input  1  one-`clk` pulse from the FIR at the start of each new output sample; the commit point.
- `coeffs`  output  `NTaps*DataWidth`  active bank; tap k occupies bits `[k*DataWidth +: DataWidth]`; signed two's complement.
- `coeffValid`  output  1  high once at least one frame has been committed since reset.
- `updatePulse`  output  1  one-`clk` pulse in the cycle the active bank changes.
- `frameError`  output  1  sticky; set on a bad frame, cleared by the next good commit.

## Operation
- **Synchronisation:** `spiClk`, `cs`, `mosi` each pass through 2 flops, plus a third flop for edge detect on `spiClk` and `cs`. All logic uses the synchronised versions only.
- **SPI format:** mode 0, MSB first. A bit is sampled on each synchronised `spiClk` rising edge while synchronised `cs` = 0.
- **States:**
  - `IDLE`: on `cs` falling edge, clear the bit counter (3 b) and the tap counter, then go to `RECV`.
  - `RECV`:
    - Every 8 bits, write the byte to shadow[tapCnt] and increment `tapCnt`.
    - Bytes after tap `NTaps-1` are dropped and mark the frame as overrun.
    - On `cs` rising edge, evaluate the frame. It is good if `tapCnt == NTaps`, the bit counter is 0, and there is no overrun. A good frame goes to `PENDING`; a bad frame sets `frameError` and goes to `IDLE`.
  - `PENDING`: on `sampleStrobe`, copy shadow to active, pulse `updatePulse`, set `coeffValid`, clear `frameError`, and go to `IDLE`.
    - A `cs` falling edge while in `PENDING` sets `frameError`.
    - That frame's bits are ignored: no shadow writes, and the state stays `PENDING`.
- **Bad frame:** the shadow bank may hold partial data, but the active bank is untouched.
- **Simultaneous events:**
  - If a `spiClk` rising edge and a `cs` rising edge are detected in the same cycle, the bit is taken first, then the frame is evaluated.
  - A `sampleStrobe` in the same cycle that `PENDING` is entered is not used; the commit waits for the next strobe.
- **Reset mid-frame:** all state returns to reset values immediately. A `cs` still low after reset release is not treated as a frame; the first frame requires a fresh `cs` falling edge.

## Timing
- **Reset values:**
  - `coeffs` = all 0, `coeffValid` = 0, `updatePulse` = 0, `frameError` = 0.
  - Shadow bank = 0, state = `IDLE`, all synchroniser flops = 1 for `cs` and 0 for `spiClk`/`mosi`.
- **Pin-to-capture latency:** a pin `spiClk` rising edge is seen 3 `clk` cycles later. `mosi` is taken from its synchroniser in the same cycle.
- **Required ratios:**
  - `spiClk` high and low phases are each ≥ 3 `clk` periods.
  - `mosi` is stable from 3 `clk` periods before to 3 `clk` periods after each `spiClk` rise.
  - `cs` rises ≥ 3 `clk` periods after the last `spiClk` rise.
- **Commit:** `coeffs` and `updatePulse` change in the cycle after the `clk` edge that samples `sampleStrobe` = 1 in `PENDING`. `updatePulse` is high for exactly 1 cycle.
- `frameError` updates 1 cycle after the offending synchronised `cs` edge.
- `coeffs` is registered and otherwise constant; there are no glitches on it between commits.

## Test plan
1. **Good frame:**
   - Stimulus: reset, then send 11 bytes 0x01..0x0B, raise `cs`, pulse `sampleStrobe`.
   - Required: `coeffs[7:0]`=0x01 and `coeffs[87:80]`=0x0B; `updatePulse` high 1 cycle; `coeffValid`=1; `frameError`=0.
2. **Commit deferral:**
   - Stimulus: after a good frame, hold `sampleStrobe` low for 100 cycles.
   - Required: `coeffs` is unchanged, then updates 1 cycle after the strobe.
3. **Short frame:**
   - Stimulus: 10 bytes, or 11 bytes plus 3 extra bits.
   - Required: `frameError`=1; `coeffs` keeps its prior value; no `updatePulse`. A following good frame of 0x7F×11 commits and clears `frameError`.
4. **Overrun:**
   - Stimulus: 12 bytes.
   - Required: `frameError`=1; active bank unchanged.
5. **Busy:**
   - Stimulus: good frame A = 0x10×11, then frame B = 0x20×11 sent before any strobe, then a strobe.
   - Required: `frameError`=1 and `coeffs` = all 0x10. B is ignored.
6. **Reset mid-frame:**
   - Stimulus: assert `resetN` low after 5 bytes; release with `cs` still low; keep clocking 6 bytes, raise `cs`, strobe.
   - Required: all outputs 0; no commit; `frameError`=0.
